// File: rtl/video_timing_pkg.sv
// Shared constants and types for the raster timing generator.
// Defaults describe 1280x720p60 at a 74.25 MHz pixel clock.
package video_timing_pkg;

    localparam int DEF_X_BITS   = 13;
    localparam int DEF_Y_BITS   = 13;

    localparam int DEF_H_ACTIVE = 1280;
    localparam int DEF_H_FRONT  = 110;
    localparam int DEF_H_SYNC   = 40;
    localparam int DEF_H_BACK   = 220;

    localparam int DEF_V_ACTIVE = 720;
    localparam int DEF_V_FRONT  = 5;
    localparam int DEF_V_SYNC   = 5;
    localparam int DEF_V_BACK   = 20;

    // Regions in the order they occur along an axis.
    typedef enum logic [1:0] {
        ACTIVE,
        FRONT,
        SYNC,
        BACK
    } region_t;

endpackage

// File: rtl/timing_axis_counter.sv
// One raster axis: a wrapping position counter plus decode of the
// active / front porch / sync / back porch regions. Region boundaries are
// summed at counter width, so a zero-length porch or sync simply vanishes.
module timing_axis_counter
    import video_timing_pkg::*;
#(
    parameter int BITS = DEF_X_BITS
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            advance,
    input  logic [BITS-1:0] active,
    input  logic [BITS-1:0] front,
    input  logic [BITS-1:0] sync,
    input  logic [BITS-1:0] back,
    output logic [BITS-1:0] count,
    output logic            in_active,
    output logic            in_sync,
    output logic            wrap
);

    localparam logic [BITS-1:0] ONE = BITS'(1);

    logic [BITS-1:0] r_count;
    logic [BITS-1:0] w_total;
    logic [BITS-1:0] w_syncStart;
    logic [BITS-1:0] w_backStart;
    region_t         w_region;

    assign w_total     = active + front + sync + back;
    assign w_syncStart = active + front;
    assign w_backStart = w_syncStart + sync;
    assign wrap        = (r_count == (w_total - ONE));

    // Position counter: steps on advance and returns to zero after the last position.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count <= '0;
        end else if (advance) begin
            r_count <= wrap ? '0 : (r_count + ONE);
        end
    end

    // Region decode; an empty region is skipped because its bounds coincide.
    always_comb begin
        w_region = BACK;
        if (r_count < active) begin
            w_region = ACTIVE;
        end else if (r_count < w_syncStart) begin
            w_region = FRONT;
        end else if (r_count < w_backStart) begin
            w_region = SYNC;
        end
    end

    assign count     = r_count;
    assign in_active = (w_region == ACTIVE);
    assign in_sync   = (w_region == SYNC);

endmodule

// File: rtl/video_timing_gen.sv
// Free-running raster timing generator (x/y, syncs, active, line/frame markers).
// Optional feature macro: VTG_RUNTIME_CFG_EN adds the cfg_* ports, which are
// captured into shadow registers on the last pixel of a frame so new timing
// always starts cleanly at the next frame. Without it the timing is fixed by
// the parameters.
module video_timing_gen
    import video_timing_pkg::*;
#(
    parameter int X_BITS   = DEF_X_BITS,
    parameter int Y_BITS   = DEF_Y_BITS,
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_FRONT  = DEF_H_FRONT,
    parameter int H_SYNC   = DEF_H_SYNC,
    parameter int H_BACK   = DEF_H_BACK,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_FRONT  = DEF_V_FRONT,
    parameter int V_SYNC   = DEF_V_SYNC,
    parameter int V_BACK   = DEF_V_BACK,
    parameter bit HS_POL   = 1'b1,
    parameter bit VS_POL   = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
`ifdef VTG_RUNTIME_CFG_EN
    input  logic [X_BITS-1:0] cfg_h_active,
    input  logic [X_BITS-1:0] cfg_h_front,
    input  logic [X_BITS-1:0] cfg_h_sync,
    input  logic [X_BITS-1:0] cfg_h_back,
    input  logic [Y_BITS-1:0] cfg_v_active,
    input  logic [Y_BITS-1:0] cfg_v_front,
    input  logic [Y_BITS-1:0] cfg_v_sync,
    input  logic [Y_BITS-1:0] cfg_v_back,
`endif
    output logic [X_BITS-1:0] x,
    output logic [Y_BITS-1:0] y,
    output logic              hsync,
    output logic              vsync,
    output logic              active,
    output logic              line_start,
    output logic              frame_start,
    output logic [X_BITS-1:0] total_active_pix
);

    logic [X_BITS-1:0] w_hActive;
    logic [X_BITS-1:0] w_hFront;
    logic [X_BITS-1:0] w_hSync;
    logic [X_BITS-1:0] w_hBack;
    logic [Y_BITS-1:0] w_vActive;
    logic [Y_BITS-1:0] w_vFront;
    logic [Y_BITS-1:0] w_vSync;
    logic [Y_BITS-1:0] w_vBack;

    logic [X_BITS-1:0] w_hCount;
    logic [Y_BITS-1:0] w_vCount;
    logic              w_hActiveRgn;
    logic              w_hSyncRgn;
    logic              w_hWrap;
    logic              w_vActiveRgn;
    logic              w_vSyncRgn;
    logic              w_vWrap;

`ifdef VTG_RUNTIME_CFG_EN
    logic [X_BITS-1:0] r_hActive;
    logic [X_BITS-1:0] r_hFront;
    logic [X_BITS-1:0] r_hSync;
    logic [X_BITS-1:0] r_hBack;
    logic [Y_BITS-1:0] r_vActive;
    logic [Y_BITS-1:0] r_vFront;
    logic [Y_BITS-1:0] r_vSync;
    logic [Y_BITS-1:0] r_vBack;
    logic              w_frameEnd;

    assign w_frameEnd = enable & w_hWrap & w_vWrap;

    // Shadow timing: capture the cfg ports only on the final pixel of a frame.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_hActive <= X_BITS'(H_ACTIVE);
            r_hFront  <= X_BITS'(H_FRONT);
            r_hSync   <= X_BITS'(H_SYNC);
            r_hBack   <= X_BITS'(H_BACK);
            r_vActive <= Y_BITS'(V_ACTIVE);
            r_vFront  <= Y_BITS'(V_FRONT);
            r_vSync   <= Y_BITS'(V_SYNC);
            r_vBack   <= Y_BITS'(V_BACK);
        end else if (w_frameEnd) begin
            r_hActive <= cfg_h_active;
            r_hFront  <= cfg_h_front;
            r_hSync   <= cfg_h_sync;
            r_hBack   <= cfg_h_back;
            r_vActive <= cfg_v_active;
            r_vFront  <= cfg_v_front;
            r_vSync   <= cfg_v_sync;
            r_vBack   <= cfg_v_back;
        end
    end

    assign w_hActive = r_hActive;
    assign w_hFront  = r_hFront;
    assign w_hSync   = r_hSync;
    assign w_hBack   = r_hBack;
    assign w_vActive = r_vActive;
    assign w_vFront  = r_vFront;
    assign w_vSync   = r_vSync;
    assign w_vBack   = r_vBack;
`else
    logic w_unusedVWrap;

    assign w_hActive     = X_BITS'(H_ACTIVE);
    assign w_hFront      = X_BITS'(H_FRONT);
    assign w_hSync       = X_BITS'(H_SYNC);
    assign w_hBack       = X_BITS'(H_BACK);
    assign w_vActive     = Y_BITS'(V_ACTIVE);
    assign w_vFront      = Y_BITS'(V_FRONT);
    assign w_vSync       = Y_BITS'(V_SYNC);
    assign w_vBack       = Y_BITS'(V_BACK);
    assign w_unusedVWrap = w_vWrap;
`endif

    timing_axis_counter #(
        .BITS (X_BITS)
    ) u_hAxis (
        .clk       (clk),
        .reset     (reset),
        .advance   (enable),
        .active    (w_hActive),
        .front     (w_hFront),
        .sync      (w_hSync),
        .back      (w_hBack),
        .count     (w_hCount),
        .in_active (w_hActiveRgn),
        .in_sync   (w_hSyncRgn),
        .wrap      (w_hWrap)
    );

    timing_axis_counter #(
        .BITS (Y_BITS)
    ) u_vAxis (
        .clk       (clk),
        .reset     (reset),
        .advance   (enable & w_hWrap),
        .active    (w_vActive),
        .front     (w_vFront),
        .sync      (w_vSync),
        .back      (w_vBack),
        .count     (w_vCount),
        .in_active (w_vActiveRgn),
        .in_sync   (w_vSyncRgn),
        .wrap      (w_vWrap)
    );

    // Registered outputs trail the counters by one enabled cycle and hold while disabled.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            x           <= '0;
            y           <= '0;
            active      <= 1'b0;
            hsync       <= ~HS_POL;
            vsync       <= ~VS_POL;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end else if (enable) begin
            x           <= w_hCount;
            y           <= w_vCount;
            active      <= w_hActiveRgn & w_vActiveRgn;
            hsync       <= w_hSyncRgn ? HS_POL : ~HS_POL;
            vsync       <= w_vSyncRgn ? VS_POL : ~VS_POL;
            line_start  <= (w_hCount == '0);
            frame_start <= (w_hCount == '0) && (w_vCount == '0);
        end
    end

    assign total_active_pix = w_hActive;

endmodule

// File: tb/tb_video_timing_gen.sv
// Directed bench for video_timing_gen using a shrunken raster:
// h 16/3/4/5 (28 per line), v 6/2/2/3 (13 lines), 364 pixels per frame,
// hsync active-high, vsync active-low. Runtime-configuration scenarios are
// built only when VTG_RUNTIME_CFG_EN is defined.
module tb_video_timing_gen;

    localparam int XB = 8;
    localparam int YB = 6;

    logic          clk = 1'b0;
    logic          reset;
    logic          enable;
    logic [XB-1:0] x;
    logic [YB-1:0] y;
    logic          hsync;
    logic          vsync;
    logic          active;
    logic          line_start;
    logic          frame_start;
    logic [XB-1:0] total_active_pix;

    int vectors = 0;
    int miscompares = 0;

    // Reference state: kf is the index within the frame of the pixel the
    // outputs currently show (-1 while in reset); dH/dV is the timing of that
    // frame, sH/sV the captured timing, cH/cV what the bench drives on cfg_*.
    int kf;
    int dH[4];
    int dV[4];
    int sH[4];
    int sV[4];
    int cH[4] = '{16, 3, 4, 5};
    int cV[4] = '{6, 2, 2, 3};

    int enCycles = 0;
    int lastLineCyc;
    int lastLineLen;
    int lastFrameCyc;
    int lastFrameLen;
    int hsRun;
    int hsStartX;
    bit prevHs;
    bit prevVs;

`ifdef VTG_RUNTIME_CFG_EN
    logic [XB-1:0] cfgHActive, cfgHFront, cfgHSync, cfgHBack;
    logic [YB-1:0] cfgVActive, cfgVFront, cfgVSync, cfgVBack;

    assign cfgHActive = XB'(cH[0]);
    assign cfgHFront  = XB'(cH[1]);
    assign cfgHSync   = XB'(cH[2]);
    assign cfgHBack   = XB'(cH[3]);
    assign cfgVActive = YB'(cV[0]);
    assign cfgVFront  = YB'(cV[1]);
    assign cfgVSync   = YB'(cV[2]);
    assign cfgVBack   = YB'(cV[3]);
`endif

    video_timing_gen #(
        .X_BITS   (XB),
        .Y_BITS   (YB),
        .H_ACTIVE (16),
        .H_FRONT  (3),
        .H_SYNC   (4),
        .H_BACK   (5),
        .V_ACTIVE (6),
        .V_FRONT  (2),
        .V_SYNC   (2),
        .V_BACK   (3),
        .HS_POL   (1'b1),
        .VS_POL   (1'b0)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .enable           (enable),
`ifdef VTG_RUNTIME_CFG_EN
        .cfg_h_active     (cfgHActive),
        .cfg_h_front      (cfgHFront),
        .cfg_h_sync       (cfgHSync),
        .cfg_h_back       (cfgHBack),
        .cfg_v_active     (cfgVActive),
        .cfg_v_front      (cfgVFront),
        .cfg_v_sync       (cfgVSync),
        .cfg_v_back       (cfgVBack),
`endif
        .x                (x),
        .y                (y),
        .hsync            (hsync),
        .vsync            (vsync),
        .active           (active),
        .line_start       (line_start),
        .frame_start      (frame_start),
        .total_active_pix (total_active_pix)
    );

    // Free-running pixel clock, 10 time units per period.
    always #5 clk = ~clk;

    function automatic int hTot();
        return dH[0] + dH[1] + dH[2] + dH[3];
    endfunction

    function automatic int vTot();
        return dV[0] + dV[1] + dV[2] + dV[3];
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        if (observed !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", tag, observed, expected, $time);
        end
    endtask

    task automatic resetModel();
        kf           = -1;
        dH           = '{16, 3, 4, 5};
        dV           = '{6, 2, 2, 3};
        sH           = dH;
        sV           = dV;
        lastLineCyc  = -1;
        lastLineLen  = 0;
        lastFrameCyc = -1;
        lastFrameLen = 0;
        hsRun        = 0;
        hsStartX     = 0;
        prevHs       = 1'b0;
        prevVs       = 1'b0;
    endtask

    task automatic stepModel(input bit en);
        if (reset) begin
            resetModel();
        end else if (en) begin
            enCycles++;
            if (kf < 0) begin
                kf = 0;
            end else begin
                kf++;
                if (kf == hTot() * vTot()) begin
                    kf = 0;
                    dH = sH;
                    dV = sV;
                end
            end
`ifdef VTG_RUNTIME_CFG_EN
            if (kf == hTot() * vTot() - 1) begin
                sH = cH;
                sV = cV;
            end
`endif
        end
    endtask

    task automatic checkAll(input bit en);
        int ex, ey;
        bit eAct, eHs, eVs, eLs, eFs, hsIn, vsIn, hsNow, vsNow;
        if (kf < 0) begin
            ex = 0; ey = 0; eAct = 0; eHs = 0; eVs = 1; eLs = 0; eFs = 0;
        end else begin
            ex   = kf % hTot();
            ey   = kf / hTot();
            eAct = (ex < dH[0]) && (ey < dV[0]);
            hsIn = (ex >= dH[0] + dH[1]) && (ex < dH[0] + dH[1] + dH[2]);
            vsIn = (ey >= dV[0] + dV[1]) && (ey < dV[0] + dV[1] + dV[2]);
            eHs  = hsIn;
            eVs  = !vsIn;
            eLs  = (ex == 0);
            eFs  = (ex == 0) && (ey == 0);
        end
        checkOutput("x", x, ex);
        checkOutput("y", y, ey);
        checkOutput("active", active, eAct);
        checkOutput("hsync", hsync, eHs);
        checkOutput("vsync", vsync, eVs);
        checkOutput("line_start", line_start, eLs);
        checkOutput("frame_start", frame_start, eFs);
        checkOutput("total_active_pix", total_active_pix, sH[0]);

        if (en && !reset && kf >= 0) begin
            if (line_start) begin
                if (lastLineCyc >= 0) checkOutput("linePeriod", enCycles - lastLineCyc, lastLineLen);
                lastLineCyc = enCycles;
                lastLineLen = hTot();
            end
            if (frame_start) begin
                if (lastFrameCyc >= 0) checkOutput("framePeriod", enCycles - lastFrameCyc, lastFrameLen);
                lastFrameCyc = enCycles;
                lastFrameLen = hTot() * vTot();
            end
            hsNow = (hsync == 1'b1);
            if (hsNow && !prevHs) begin
                hsRun    = 1;
                hsStartX = int'(x);
            end else if (hsNow) begin
                hsRun++;
            end else if (prevHs) begin
                checkOutput("hsyncLen", hsRun, dH[2]);
                checkOutput("hsyncStartX", hsStartX, dH[0] + dH[1]);
            end
            prevHs = hsNow;
            vsNow = (vsync == 1'b0);
            if (vsNow != prevVs) checkOutput("vsyncEdgeX", x, 0);
            prevVs = vsNow;
        end
    endtask

    task automatic applyStimulus(input bit en, input int n);
        for (int i = 0; i < n; i++) begin
            enable = en;
            @(posedge clk);
            stepModel(en);
            #1;
            checkAll(en);
        end
    endtask

    task automatic runUntil(input int target);
        int guard;
        guard = 0;
        while (kf != target && guard < 4000) begin
            applyStimulus(1'b1, 1);
            guard++;
        end
    endtask

    initial begin
        reset  = 1'b1;
        enable = 1'b0;
        resetModel();

        // Reset state, including held-in-reset with enable low.
        applyStimulus(1'b0, 2);
        checkOutput("rstTotalPix", total_active_pix, 16);
        checkOutput("rstVsyncLevel", vsync, 1);

        // First enabled edge after release shows pixel (0,0) with both markers.
        reset = 1'b0;
        applyStimulus(1'b1, 1);
        checkOutput("firstX", x, 0);
        checkOutput("firstY", y, 0);
        checkOutput("firstActive", active, 1);
        checkOutput("firstLineStart", line_start, 1);
        checkOutput("firstFrameStart", frame_start, 1);

        // A frame and a bit: line/frame periods, hsync window, vsync edges.
        applyStimulus(1'b1, 463);

        // Freeze 17 cycles mid-line, then 5 cycles while line_start is high.
        runUntil(5 * 28 + 10);
        applyStimulus(1'b0, 17);
        checkOutput("frozenX", x, 10);
        checkOutput("frozenY", y, 5);
        runUntil(6 * 28);
        applyStimulus(1'b0, 5);
        checkOutput("frozenLineStart", line_start, 1);
        applyStimulus(1'b1, 400);

`ifdef VTG_RUNTIME_CFG_EN
        // Mid-frame load of a smaller raster: current frame finishes unchanged.
        runUntil(150);
        cH = '{10, 1, 2, 3};
        cV = '{4, 1, 1, 2};
        applyStimulus(1'b1, 364 - 150 - 1);
        checkOutput("cfgOldFrameX", x, 27);
        checkOutput("cfgOldFrameY", y, 12);
        checkOutput("cfgTotalPixSwap", total_active_pix, 10);
        applyStimulus(1'b1, 1);
        checkOutput("cfgNewFrameStart", frame_start, 1);
        checkOutput("cfgNewTotalPix", total_active_pix, 10);
        applyStimulus(1'b1, 140);

        // Zero sync length: hsync never asserts, line shrinks to 24.
        cH = '{16, 3, 0, 5};
        cV = '{6, 2, 2, 3};
        applyStimulus(1'b1, 128 + 312 + 10);
        cH = '{16, 3, 4, 5};
        applyStimulus(1'b1, 312 + 364);
`endif

        // Asynchronous reset mid-frame at (10,3), checked before any clock edge.
        runUntil(3 * 28 + 10);
        #2;
        reset = 1'b1;
        #1;
        resetModel();
        checkAll(1'b0);
        checkOutput("asyncRstX", x, 0);
        checkOutput("asyncRstY", y, 0);
        applyStimulus(1'b1, 3);
        reset = 1'b0;
        applyStimulus(1'b1, 1);
        checkOutput("restartX", x, 0);
        checkOutput("restartFrameStart", frame_start, 1);
        applyStimulus(1'b1, 60);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
